game_state_fsm: RTL and testbench
=================================

// Module: game_state_fsm
// PURPOSE
//  Top-level game state machine for the single-player shooter. Generalises the
//  press-start/playing/game-over flow to NUM_ENEMIES enemies, a lives counter
//  and a timed respawn phase. Sits between the object/collision datapath and
//  the VGA renderer/score logic, which decode `state`.
// PARAMETERS
//  NUM_ENEMIES    8    number of enemy vertical-position channels
//  COORD_W        10   coordinate width (pixels)
//  PLANE_W        20   plane hit-box width in pixels, starting at plane_h
//  DEFEAT_LINE    380  enemy_v >= this on any alive enemy ends the game
//  LIVES          3    lives loaded on game start (>=1)
//  RESPAWN_TICKS  60   frame ticks spent in HIT before resuming (>=1)
// PORTS
//  clk            in   1                     system clock
//  reset          in   1                     async, active-high
//  start          in   1                     start/continue button, level
//  tick           in   1                     1-cycle frame strobe
//  plane_h        in   COORD_W               plane left x
//  enemy_laser_h  in   COORD_W               enemy laser x
//  laser_valid    in   1                     laser at plane row this cycle
//  enemy_v        in   NUM_ENEMIES*COORD_W   packed; enemy i = [i*COORD_W +: COORD_W]
//  enemy_alive    in   NUM_ENEMIES           1 = enemy i counts for invasion
//  state          out  2                     0 IDLE,1 PLAYING,2 HIT,3 GAMEOVER
//  lives          out  $clog2(LIVES+1)       remaining lives
//  hit_pulse      out  1                     1 cycle on accepted laser hit
//  over_pulse     out  1                     1 cycle on entry to GAMEOVER
// BEHAVIOUR
//  Reset: state=IDLE, lives=LIVES, respawn_cnt=0, hit_pulse=0, over_pulse=0.
//  All outputs registered; a condition sampled in cycle N is visible in N+1.
//  laser_hit = laser_valid & (enemy_laser_h >= plane_h) &
//     (enemy_laser_h < plane_h+PLANE_W), the sum computed in COORD_W+1 bits (no wrap).
//  invade = OR over i of (enemy_alive[i] & enemy_v[i] >= DEFEAT_LINE); dead
//     enemies are ignored.
//  IDLE: start -> PLAYING, lives<=LIVES. Otherwise hold.
//  PLAYING: invade -> GAMEOVER, lives<=0 (priority over laser_hit).
//     else laser_hit & lives==1 -> GAMEOVER, lives<=0, hit_pulse.
//     else laser_hit -> HIT, lives<=lives-1, respawn_cnt<=RESPAWN_TICKS, hit_pulse.
//  HIT: laser_hit is ignored (invulnerable). invade -> GAMEOVER, lives<=0.
//     tick decrements respawn_cnt; tick with respawn_cnt==1 -> PLAYING.
//  GAMEOVER: start -> IDLE (next press restarts). No direct jump to PLAYING.
//  over_pulse is asserted in the cycle state first reads GAMEOVER, from any source state.
//  start held continuously: IDLE->PLAYING, and later GAMEOVER->IDLE->PLAYING on
//     consecutive cycles. This is intended.
//  tick and laser_hit arriving in the same cycle in PLAYING: the hit is taken and
//     respawn_cnt loads RESPAWN_TICKS with no decrement.
// CONFIGURATION
//  GAME_PAUSE_EN defined: adds input `pause` (1b, level) and output `paused`
//     (1b, reset 0). A rising edge of pause in PLAYING or HIT toggles `paused`.
//     While paused, state, lives and respawn_cnt freeze, and hit and invade are
//     ignored. Entering IDLE or GAMEOVER clears `paused`.
//  GAME_PAUSE_EN undefined: no pause port, no paused port, no freeze logic.
// TESTING
//  Reset, then start=1 for 1 cycle -> state 0->1, lives=3, no pulses.
//  PLAYING, plane_h=100, laser_valid=1, enemy_laser_h=119 -> hit_pulse, state=2,
//     lives=2. Same test with enemy_laser_h=120 -> no hit.
//  HIT with RESPAWN_TICKS=4: re-fire laser -> ignored; the 4th tick -> state=1
//     on the next cycle.
//  Three hits separated by respawns -> the 3rd gives state=3, lives=0, with
//     hit_pulse and over_pulse both asserted once.
//  enemy_v[5]=380 with alive[5]=0 -> stays 1; set alive[5]=1 -> state=3 even
//     with a laser hit in the same cycle (lives=0, no hit_pulse).
//  GAMEOVER, start=1 -> state=0; a second start -> state=1, lives=3.
//  GAME_PAUSE_EN: in HIT with respawn_cnt=3, pause edge, 10 ticks -> cnt stays 3;
//     unpause, then 3 ticks -> state=1.

Source files
------------

// File: rtl/game_state_fsm_if.sv
// ---------------------------------------------------------------------------
// game_state_fsm_if
//  Bundles the signals between the object/collision datapath, the game state
//  machine and the renderer/score logic.
//  Modports:
//    master : datapath/bench side. Drives the controls and object positions
//             and reads back the game state.
//    slave  : game_state_fsm side. Reads the controls and positions and
//             drives state, lives and the event pulses.
//  Signals:
//    start, tick, laser_valid          1-bit controls (tick is a frame strobe)
//    plane_h, enemy_laser_h            COORD_W x positions
//    enemy_v                           NUM_ENEMIES*COORD_W packed enemy rows
//    enemy_alive                       NUM_ENEMIES alive flags
//    state, lives, hit_pulse,
//    over_pulse                        registered FSM outputs
//  Optional feature macro: GAME_PAUSE_EN adds pause (in) and paused (out).
// ---------------------------------------------------------------------------
interface game_state_fsm_if #(
  parameter int NUM_ENEMIES = 8,
  parameter int COORD_W     = 10,
  parameter int LIVES       = 3
);
  logic                           start;
  logic                           tick;
  logic [COORD_W-1:0]             plane_h;
  logic [COORD_W-1:0]             enemy_laser_h;
  logic                           laser_valid;
  logic [NUM_ENEMIES*COORD_W-1:0] enemy_v;
  logic [NUM_ENEMIES-1:0]         enemy_alive;
  logic [1:0]                     state;
  logic [$clog2(LIVES+1)-1:0]     lives;
  logic                           hit_pulse;
  logic                           over_pulse;
`ifdef GAME_PAUSE_EN
  logic                           pause;
  logic                           paused;
`endif

  modport master (
    output start, tick, plane_h, enemy_laser_h, laser_valid, enemy_v, enemy_alive,
`ifdef GAME_PAUSE_EN
    output pause,
    input  paused,
`endif
    input  state, lives, hit_pulse, over_pulse
  );

  modport slave (
    input  start, tick, plane_h, enemy_laser_h, laser_valid, enemy_v, enemy_alive,
`ifdef GAME_PAUSE_EN
    input  pause,
    output paused,
`endif
    output state, lives, hit_pulse, over_pulse
  );
endinterface

// File: rtl/game_state_fsm.sv
// ---------------------------------------------------------------------------
// game_state_fsm
//  Top-level game flow for the single-player shooter:
//  IDLE -> PLAYING -> (HIT respawn phase) -> GAMEOVER -> IDLE.
//  Tracks a lives counter, a timed respawn phase counted in frame ticks,
//  and a defeat condition when any alive enemy reaches DEFEAT_LINE.
//  Ports:
//    clk        system clock
//    reset      asynchronous, active-high
//    game_bus   game_state_fsm_if.slave (controls/positions in, state out)
//  state encoding: 0 IDLE, 1 PLAYING, 2 HIT, 3 GAMEOVER.
//  All outputs are registered: a condition sampled in cycle N shows in N+1.
//  Optional feature macro: GAME_PAUSE_EN. When defined, a rising edge of
//  pause in PLAYING/HIT toggles paused; while paused, state, lives and the
//  respawn counter freeze. Entering IDLE or GAMEOVER clears paused.
// ---------------------------------------------------------------------------
module game_state_fsm #(
  parameter int NUM_ENEMIES   = 8,
  parameter int COORD_W       = 10,
  parameter int PLANE_W       = 20,
  parameter int DEFEAT_LINE   = 380,
  parameter int LIVES         = 3,
  parameter int RESPAWN_TICKS = 60
) (
  input logic               clk,
  input logic               reset,
  game_state_fsm_if.slave   game_bus
);

  localparam int LW = $clog2(LIVES + 1);
  localparam int CW = $clog2(RESPAWN_TICKS + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PLAYING  = 2'd1,
    HIT      = 2'd2,
    GAMEOVER = 2'd3
  } state_t;

  state_t          state_r;
  logic [LW-1:0]   lives_r;
  logic [CW-1:0]   respawn_cnt;
  logic            hit_pulse_r;
  logic            over_pulse_r;
  logic            laser_hit;
  logic            invade;
  logic            frozen;
  logic [COORD_W:0] plane_right;

  // Right edge of the hit box is computed one bit wider so a plane near the
  // right screen edge does not wrap and make the box empty.
  assign plane_right = {1'b0, game_bus.plane_h} + (COORD_W+1)'(PLANE_W);

  assign laser_hit = game_bus.laser_valid &&
                     (game_bus.enemy_laser_h >= game_bus.plane_h) &&
                     ({1'b0, game_bus.enemy_laser_h} < plane_right);

  always_comb begin
    invade = 1'b0;
    for (int i = 0; i < NUM_ENEMIES; i++) begin
      if (game_bus.enemy_alive[i] &&
          (game_bus.enemy_v[i*COORD_W +: COORD_W] >= COORD_W'(DEFEAT_LINE)))
        invade = 1'b1;
    end
  end

`ifdef GAME_PAUSE_EN
  logic paused_r;
  logic pause_q;
  logic pause_rise;

  assign pause_rise      = game_bus.pause && !pause_q;
  assign frozen          = paused_r;
  assign game_bus.paused = paused_r;
`else
  assign frozen = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      lives_r      <= LW'(LIVES);
      respawn_cnt  <= '0;
      hit_pulse_r  <= 1'b0;
      over_pulse_r <= 1'b0;
`ifdef GAME_PAUSE_EN
      paused_r     <= 1'b0;
      pause_q      <= 1'b0;
`endif
    end else begin
      hit_pulse_r  <= 1'b0;
      over_pulse_r <= 1'b0;
`ifdef GAME_PAUSE_EN
      pause_q <= game_bus.pause;
      if (pause_rise && (state_r == PLAYING || state_r == HIT))
        paused_r <= ~paused_r;
`endif
      if (!frozen) begin
        case (state_r)
          IDLE: begin
            if (game_bus.start) begin
              state_r <= PLAYING;
              lives_r <= LW'(LIVES);
            end
          end

          PLAYING: begin
            // Invasion outranks a simultaneous laser hit.
            if (invade) begin
              state_r      <= GAMEOVER;
              lives_r      <= '0;
              over_pulse_r <= 1'b1;
`ifdef GAME_PAUSE_EN
              paused_r     <= 1'b0;
`endif
            end else if (laser_hit && lives_r == LW'(1)) begin
              state_r      <= GAMEOVER;
              lives_r      <= '0;
              hit_pulse_r  <= 1'b1;
              over_pulse_r <= 1'b1;
`ifdef GAME_PAUSE_EN
              paused_r     <= 1'b0;
`endif
            end else if (laser_hit) begin
              // A tick in the same cycle is deliberately not counted.
              state_r     <= HIT;
              lives_r     <= lives_r - LW'(1);
              respawn_cnt <= CW'(RESPAWN_TICKS);
              hit_pulse_r <= 1'b1;
            end
          end

          HIT: begin
            // Laser hits are ignored here: the plane is invulnerable.
            if (invade) begin
              state_r      <= GAMEOVER;
              lives_r      <= '0;
              over_pulse_r <= 1'b1;
`ifdef GAME_PAUSE_EN
              paused_r     <= 1'b0;
`endif
            end else if (game_bus.tick) begin
              respawn_cnt <= respawn_cnt - CW'(1);
              if (respawn_cnt == CW'(1))
                state_r <= PLAYING;
            end
          end

          GAMEOVER: begin
            if (game_bus.start) begin
              state_r <= IDLE;
`ifdef GAME_PAUSE_EN
              paused_r <= 1'b0;
`endif
            end
          end

          default: state_r <= IDLE;
        endcase
      end
    end
  end

  assign game_bus.state      = state_r;
  assign game_bus.lives      = lives_r;
  assign game_bus.hit_pulse  = hit_pulse_r;
  assign game_bus.over_pulse = over_pulse_r;

endmodule

// File: tb/tb_game_state_fsm.sv
// ---------------------------------------------------------------------------
// tb_game_state_fsm
//  Directed bench for game_state_fsm with RESPAWN_TICKS=4, other parameters
//  at their defaults. Inputs are driven 1 ns after a rising edge; outputs are
//  checked 1 ns after the following rising edge.
//  Optional feature macro: GAME_PAUSE_EN enables the pause scenario.
// ---------------------------------------------------------------------------
module tb_game_state_fsm;
  localparam int NUM_ENEMIES = 8;
  localparam int COORD_W     = 10;
  localparam int LIVES       = 3;

  logic clk;
  logic reset;
  int   total;
  int   passed;

  game_state_fsm_if #(.NUM_ENEMIES(NUM_ENEMIES), .COORD_W(COORD_W), .LIVES(LIVES)) gif ();

  game_state_fsm #(
    .NUM_ENEMIES(NUM_ENEMIES), .COORD_W(COORD_W), .PLANE_W(20),
    .DEFEAT_LINE(380), .LIVES(LIVES), .RESPAWN_TICKS(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .game_bus(gif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
  endtask

  task automatic chk_out(input string tag, input int st, input int lv, input int hp, input int op);
    chk({tag, ".state"}, 32'(gif.state), 32'(st));
    chk({tag, ".lives"}, 32'(gif.lives), 32'(lv));
    chk({tag, ".hit"},   32'(gif.hit_pulse), 32'(hp));
    chk({tag, ".over"},  32'(gif.over_pulse), 32'(op));
  endtask

  task automatic set_enemy(input int idx, input int v);
    gif.enemy_v[idx*COORD_W +: COORD_W] = COORD_W'(v);
  endtask

  initial begin
    total  = 0;
    passed = 0;
    reset  = 1'b1;
    gif.start = 0; gif.tick = 0; gif.laser_valid = 0;
    gif.plane_h = 10'd100; gif.enemy_laser_h = 10'd0;
    gif.enemy_v = '0; gif.enemy_alive = '1;
`ifdef GAME_PAUSE_EN
    gif.pause = 0;
`endif
    #12;
    chk_out("reset", 0, 3, 0, 0);
`ifdef GAME_PAUSE_EN
    chk("reset.paused", 32'(gif.paused), 0);
`endif
    @(negedge clk);
    reset = 1'b0;
    step();
    chk_out("idle_hold", 0, 3, 0, 0);

    // Start for one cycle
    gif.start = 1; step(); gif.start = 0;
    chk_out("start", 1, 3, 0, 0);

    // Hit-box boundaries with plane_h=100, PLANE_W=20
    gif.laser_valid = 1; gif.enemy_laser_h = 10'd120; step();
    chk_out("laser_120_miss", 1, 3, 0, 0);
    gif.enemy_laser_h = 10'd99; step();
    chk_out("laser_99_miss", 1, 3, 0, 0);
    gif.enemy_laser_h = 10'd119; step();
    chk_out("hit1", 2, 2, 1, 0);
    step();
    chk_out("hit1_invuln", 2, 2, 0, 0);
    gif.laser_valid = 0;

    // Respawn: 4 ticks, state returns on the cycle after the 4th
    for (int k = 0; k < 4; k++) begin
      gif.tick = 1; step(); gif.tick = 0;
      chk($sformatf("respawn1_t%0d", k + 1), 32'(gif.state), (k == 3) ? 32'd1 : 32'd2);
    end

    // Second hit with a simultaneous tick: counter loads 4 with no decrement
    gif.laser_valid = 1; gif.enemy_laser_h = 10'd110; gif.tick = 1; step();
    gif.laser_valid = 0; gif.tick = 0;
    chk_out("hit2", 2, 1, 1, 0);
    for (int k = 0; k < 4; k++) begin
      gif.tick = 1; step(); gif.tick = 0;
      chk($sformatf("respawn2_t%0d", k + 1), 32'(gif.state), (k == 3) ? 32'd1 : 32'd2);
    end

    // Third hit on the last life
    gif.laser_valid = 1; step(); gif.laser_valid = 0;
    chk_out("hit3_over", 3, 0, 1, 1);
    step();
    chk_out("over_hold", 3, 0, 0, 0);

    // GAMEOVER -> IDLE -> PLAYING by separate presses
    gif.start = 1; step(); gif.start = 0;
    chk_out("over_to_idle", 0, 0, 0, 0);
    step();
    chk_out("idle_wait", 0, 0, 0, 0);
    gif.start = 1; step(); gif.start = 0;
    chk_out("restart", 1, 3, 0, 0);

    // Dead enemy at the defeat line is ignored; alive one just above is too
    set_enemy(5, 380); set_enemy(4, 379); gif.enemy_alive = 8'hDF; step();
    chk_out("dead_enemy_ignored", 1, 3, 0, 0);
    // Enemy 5 comes alive together with a laser hit: invasion wins
    gif.enemy_alive = 8'hFF; gif.laser_valid = 1; gif.enemy_laser_h = 10'd105; step();
    gif.laser_valid = 0;
    chk_out("invade_priority", 3, 0, 0, 1);
    set_enemy(5, 0); set_enemy(4, 0);

    // Start held continuously: GAMEOVER -> IDLE -> PLAYING on consecutive cycles
    gif.start = 1; step();
    chk("held_idle", 32'(gif.state), 0);
    step(); gif.start = 0;
    chk_out("held_play", 1, 3, 0, 0);

    // Invasion while in HIT
    gif.laser_valid = 1; step(); gif.laser_valid = 0;
    chk_out("hit_again", 2, 2, 1, 0);
    set_enemy(0, 500); step();
    chk_out("invade_in_hit", 3, 0, 0, 1);
    set_enemy(0, 0);

`ifdef GAME_PAUSE_EN
    gif.start = 1; step(); step(); gif.start = 0;
    chk_out("pause_setup", 1, 3, 0, 0);
    gif.laser_valid = 1; step(); gif.laser_valid = 0;
    chk_out("pause_hit", 2, 2, 1, 0);
    gif.tick = 1; step(); gif.tick = 0;          // respawn count now 3
    chk("pause_cnt3_state", 32'(gif.state), 2);
    gif.pause = 1; step();
    chk("paused_set", 32'(gif.paused), 1);
    for (int k = 0; k < 10; k++) begin
      gif.tick = 1; step(); gif.tick = 0;
    end
    chk("paused_frozen_state", 32'(gif.state), 2);
    chk("paused_still", 32'(gif.paused), 1);
    gif.pause = 0; step();
    gif.pause = 1; step(); gif.pause = 0;
    chk("unpaused", 32'(gif.paused), 0);
    for (int k = 0; k < 3; k++) begin
      gif.tick = 1; step(); gif.tick = 0;
      chk($sformatf("unpause_t%0d", k + 1), 32'(gif.state), (k == 2) ? 32'd1 : 32'd2);
    end
    chk("unpause_lives", 32'(gif.lives), 2);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Safety net so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end
endmodule
